// File: rtl/multi_channel_tdoa_timer.sv
// Multi-channel TDOA timer: timestamps each channel's first rising edge relative to the first edge seen.
// Latency: valid/timestamp one register stage after the sampling edge; done on the same edge as the final capture or timeout.
// Backpressure: results are held in DONE until ack; an ack during CAPTURE aborts the measurement.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - asynchronous active-low reset
//   detect     - per-channel detection level, synchronous to clk
//   ack        - consumer acknowledge, level sampled on clk
//   timestamps - channel i at [i*CNT_WIDTH +: CNT_WIDTH], registered
//   valid      - channel i timestamp captured, registered
//   done       - measurement complete, results stable, registered
//   timeout    - done was caused by window expiry, registered
//   busy       - high while a capture window is open, registered
module multi_channel_tdoa_timer #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           detect,
    input  logic                          ack,
    output logic [CHANNELS*CNT_WIDTH-1:0] timestamps,
    output logic [CHANNELS-1:0]           valid,
    output logic                          done,
    output logic                          timeout,
    output logic                          busy
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [CHANNELS-1:0]  detect_d;
    logic [CHANNELS-1:0]  rise;

    logic [CNT_WIDTH-1:0] elapsed;
    logic [CNT_WIDTH-1:0] elapsed_nxt;

    logic [CNT_WIDTH-1:0] ts_q   [CHANNELS];
    logic [CNT_WIDTH-1:0] ts_nxt [CHANNELS];

    logic [CHANNELS-1:0]  valid_nxt;
    logic                 done_nxt;
    logic                 timeout_nxt;
    logic                 busy_nxt;

    // detect_d resets low, so a line already high at reset release is
    // treated as a rising edge on the first clock.
    assign rise = detect & ~detect_d;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ts_flat
            assign timestamps[g*CNT_WIDTH +: CNT_WIDTH] = ts_q[g];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            detect_d <= '0;
            elapsed  <= '0;
            valid    <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            detect_d <= detect;
            elapsed  <= elapsed_nxt;
            valid    <= valid_nxt;
            done     <= done_nxt;
            timeout  <= timeout_nxt;
            busy     <= busy_nxt;
            for (int i = 0; i < CHANNELS; i++) begin
                ts_q[i] <= ts_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        elapsed_nxt = elapsed;
        valid_nxt   = valid;
        done_nxt    = done;
        timeout_nxt = timeout;
        busy_nxt    = busy;
        for (int i = 0; i < CHANNELS; i++) begin
            ts_nxt[i] = ts_q[i];
        end

        case (state)
            ST_IDLE: begin
                // ack has no effect here; only a rising edge opens a window.
                if (|rise) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (rise[i]) begin
                            ts_nxt[i]    = '0;
                            valid_nxt[i] = 1'b1;
                        end
                    end
                    elapsed_nxt = CNT_WIDTH'(1);
                    if (&rise) begin
                        state_nxt   = ST_DONE;
                        done_nxt    = 1'b1;
                        timeout_nxt = 1'b0;
                        busy_nxt    = 1'b0;
                    end else begin
                        state_nxt = ST_CAPTURE;
                        busy_nxt  = 1'b1;
                    end
                end
            end

            ST_CAPTURE: begin
                if (ack) begin
                    // Abort: drop partial results without ever raising done.
                    state_nxt   = ST_IDLE;
                    elapsed_nxt = '0;
                    valid_nxt   = '0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        ts_nxt[i] = '0;
                    end
                end else begin
                    // First edge wins: channels already valid ignore later edges.
                    // The stored stamp is the pre-increment count.
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (rise[i] && !valid[i]) begin
                            ts_nxt[i]    = elapsed;
                            valid_nxt[i] = 1'b1;
                        end
                    end
                    // Saturate at the window length so the counter cannot
                    // run past it on the timeout transition.
                    if (elapsed != TIMEOUT_C) begin
                        elapsed_nxt = elapsed + 1'b1;
                    end
                    // Completion is checked first so a capture landing on the
                    // last window cycle reports a clean finish, not a timeout.
                    if (&valid_nxt) begin
                        state_nxt   = ST_DONE;
                        done_nxt    = 1'b1;
                        timeout_nxt = 1'b0;
                        busy_nxt    = 1'b0;
                    end else if (elapsed == TIMEOUT_C) begin
                        state_nxt   = ST_DONE;
                        done_nxt    = 1'b1;
                        timeout_nxt = 1'b1;
                        busy_nxt    = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                // Results are frozen until the consumer acknowledges.
                if (ack) begin
                    state_nxt   = ST_IDLE;
                    elapsed_nxt = '0;
                    valid_nxt   = '0;
                    done_nxt    = 1'b0;
                    timeout_nxt = 1'b0;
                    busy_nxt    = 1'b0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        ts_nxt[i] = '0;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_channel_tdoa_timer.sv
// Bench for multi_channel_tdoa_timer: directed scenarios followed by random detect/ack traffic.
// Every clock the DUT outputs are compared against an event-level model built from absolute cycle numbers.
// The model records the cycle of the window start and of each channel's first rise; expectations are differences of those.
module tb_multi_channel_tdoa_timer;

    localparam int CH  = 4;
    localparam int CW  = 16;
    localparam int TMO = 20;

    logic              clk;
    logic              rst;
    logic [CH-1:0]     detect;
    logic              ack;
    logic [CH*CW-1:0]  timestamps;
    logic [CH-1:0]     valid;
    logic              done;
    logic              timeout;
    logic              busy;

    int n_chk;
    int n_fail;

    // Model: absolute cycle numbers rather than counters or states.
    int            cyc;
    int            win_start;     // cycle of the first edge, -1 when no window
    int            first_rise[CH]; // cycle of the channel's first rise, -1 if none
    bit            finished;
    bit            expired;
    logic [CH-1:0] prev_det;

    multi_channel_tdoa_timer #(
        .CHANNELS (CH),
        .CNT_WIDTH(CW),
        .TIMEOUT  (TMO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .detect    (detect),
        .ack       (ack),
        .timestamps(timestamps),
        .valid     (valid),
        .done      (done),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] ts_of(input int ch);
        return timestamps[ch*CW +: CW];
    endfunction

    task automatic model_clear();
        win_start = -1;
        finished  = 1'b0;
        expired   = 1'b0;
        for (int i = 0; i < CH; i++) first_rise[i] = -1;
    endtask

    function automatic int captured_count();
        int n = 0;
        for (int i = 0; i < CH; i++) if (first_rise[i] >= 0) n++;
        return n;
    endfunction

    // One clock of the model, using the inputs as sampled at this edge.
    task automatic model_step(input logic [CH-1:0] det, input logic a);
        logic [CH-1:0] r;
        r = det & ~prev_det;
        if (win_start >= 0 && a) begin
            model_clear();
        end else if (win_start < 0) begin
            if (r != '0) begin
                win_start = cyc;
                for (int i = 0; i < CH; i++) if (r[i]) first_rise[i] = cyc;
                if (captured_count() == CH) finished = 1'b1;
            end
        end else if (!finished) begin
            for (int i = 0; i < CH; i++)
                if (r[i] && first_rise[i] < 0) first_rise[i] = cyc;
            if (captured_count() == CH) begin
                finished = 1'b1;
            end else if (cyc - win_start == TMO) begin
                finished = 1'b1;
                expired  = 1'b1;
            end
        end
        prev_det = det;
    endtask

    task automatic compare_all();
        logic [CH-1:0] ev;
        int            ets;
        for (int i = 0; i < CH; i++) begin
            ev[i] = (first_rise[i] >= 0);
            ets   = ev[i] ? (first_rise[i] - win_start) : 0;
            check($sformatf("ts%0d", i), 64'(ts_of(i)), 64'(ets));
        end
        check("valid", 64'(valid), 64'(ev));
        check("done", 64'(done), 64'(finished));
        check("timeout", 64'(timeout), 64'(expired));
        check("busy", 64'(busy), 64'((win_start >= 0) && !finished));
    endtask

    // Clock edge, model update from the sampled inputs, then compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step(detect, ack);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Return to idle with all detect lines low.
    task automatic settle();
        detect = '0;
        ack    = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        cyc      = 0;
        prev_det = '0;
        model_clear();
        detect = '0;
        ack    = 1'b0;
        rst    = 1'b0;

        #12;
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset mid-capture: outputs must drop without a clock edge.
        detect = 4'b0011;
        tick();
        run(2);
        check("pre_reset_valid", 64'(valid), 64'(4'b0011));
        #2;
        rst    = 1'b0;
        detect = '0;
        #1;
        check("async_valid", 64'(valid), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_ts0", 64'(ts_of(0)), 64'd0);
        check("async_done", 64'(done), 64'd0);
        prev_det = '0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(2);
        check("post_reset_busy", 64'(busy), 64'd0);

        // Staggered arrivals.
        detect = 4'b0001; tick();          // k0
        run(2);
        detect = 4'b0101; tick();          // k0+3
        tick();
        detect = 4'b0111; tick();          // k0+5
        check("stag_busy_k5", 64'(busy), 64'd1);
        tick();
        detect = 4'b1111; tick();          // k0+7
        check("stag_ts0", 64'(ts_of(0)), 64'd0);
        check("stag_ts1", 64'(ts_of(1)), 64'd5);
        check("stag_ts2", 64'(ts_of(2)), 64'd3);
        check("stag_ts3", 64'(ts_of(3)), 64'd7);
        check("stag_done", 64'(done), 64'd1);
        check("stag_tmo", 64'(timeout), 64'd0);

        // Ack in DONE with ch0 still high: no retrigger until a new rise.
        detect = 4'b0001;
        ack = 1'b1; tick(); ack = 1'b0;
        check("ack_done_valid", 64'(valid), 64'd0);
        run(3);
        check("no_retrig_busy", 64'(busy), 64'd0);
        detect = 4'b0000; tick();
        detect = 4'b0001; tick();
        check("retrig_busy", 64'(busy), 64'd1);
        settle();

        // Timeout window.
        detect = 4'b0010; tick();          // k0
        run(3);
        detect = 4'b1010; tick();          // k0+4
        run(15);                           // k0+19
        check("tmo_not_yet", 64'(done), 64'd0);
        tick();                            // k0+20
        check("tmo_done", 64'(done), 64'd1);
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_valid", 64'(valid), 64'(4'b1010));
        check("tmo_ts3", 64'(ts_of(3)), 64'd4);
        run(3);
        check("tmo_hold", 64'(done), 64'd1);
        settle();

        // Capture on the last window cycle wins over timeout.
        detect = 4'b0111; tick();          // k0
        run(19);
        detect = 4'b1111; tick();          // k0+20
        check("bnd_ts3", 64'(ts_of(3)), 64'd20);
        check("bnd_done", 64'(done), 64'd1);
        check("bnd_tmo", 64'(timeout), 64'd0);
        settle();

        // Simultaneous start and a repeated pulse on ch0.
        detect = 4'b0011; tick();          // k0
        detect = 4'b0010; tick();
        detect = 4'b0011; tick();          // k0+2
        run(3);
        detect = 4'b1111; tick();          // k0+6
        check("rep_ts0", 64'(ts_of(0)), 64'd0);
        check("rep_ts2", 64'(ts_of(2)), 64'd6);
        check("rep_ts3", 64'(ts_of(3)), 64'd6);
        check("rep_done", 64'(done), 64'd1);
        settle();

        // Abort during capture.
        detect = 4'b0001; tick();          // k0
        run(2);
        ack = 1'b1; tick(); ack = 1'b0;    // k0+3
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        run(25);
        check("abort_no_done", 64'(done), 64'd0);

        // Ack in idle does nothing.
        detect = '0;
        ack = 1'b1; tick(); ack = 1'b0;
        check("idle_ack_busy", 64'(busy), 64'd0);

        // All channels together finish immediately.
        detect = 4'b1111; tick();
        check("all_done", 64'(done), 64'd1);
        settle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 9) == 0) detect[i] = ~detect[i];
            ack = ($urandom_range(0, 24) == 0);
            tick();
        end
        ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_tdoa_timer.md
Name: multi_channel_tdoa_timer

Overview:
- Multi-channel successor to the single-channel detection timer for time-difference-of-arrival measurement.
- Watches CHANNELS detect lines and starts a relative counter on the first rising edge.
- Timestamps each channel's first rising edge relative to that start.
- Raises done when all channels are captured or a timeout window expires, then holds results until the consumer acks.

Parameters:
CHANNELS, 4, number of detect inputs (>=1)
CNT_WIDTH, 16, timestamp/elapsed counter width in bits
TIMEOUT, 1000, capture window in clk cycles after first edge; 1 <= TIMEOUT < 2^CNT_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
detect  input  CHANNELS  per-channel detection level, synchronous to clk
ack  input  1  consumer acknowledge, level sampled on clk
timestamps  output  CHANNELS*CNT_WIDTH  channel i at bits [i*CNT_WIDTH +: CNT_WIDTH], registered
valid  output  CHANNELS  channel i timestamp captured, registered
done  output  1  measurement complete; results stable, registered
timeout  output  1  done was caused by window expiry, registered
busy  output  1  high while in CAPTURE, registered

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0): state=IDLE; timestamps, valid, done, timeout, busy, elapsed and detect_d all 0, asynchronously.
- Edge detection: edge[i] = detect[i] & ~detect_d[i]. detect_d updates every cycle in every state.
- Because detect_d resets to 0, a detect line already high at reset release counts as an edge on the first clock.
- States: IDLE, CAPTURE, DONE.
- IDLE, no edge: hold.
- IDLE, edge(s) at clock k0: for each edge channel, ts=0 and valid=1; elapsed<=1.
  - If all channels edge together: go to DONE (done=1, timeout=0).
  - Otherwise: go to CAPTURE (busy=1).
- CAPTURE, every clock: elapsed<=elapsed+1.
  - An edge on a channel with valid=0 stores ts=elapsed (pre-increment value) and sets valid.
  - So an edge sampled at clock k0+n yields ts=n.
  - Edges on channels already valid are ignored (first edge wins).
- CAPTURE completion: if all valid after this clock's captures, go to DONE at this same edge with done=1, timeout=0, busy=0.
- CAPTURE timeout: else if elapsed==TIMEOUT, go to DONE with done=1, timeout=1, busy=0.
  - A capture in the same clock as elapsed==TIMEOUT is still stored (ts=TIMEOUT).
  - Completion takes priority over timeout.
- Elapsed counter range: never exceeds TIMEOUT, so no wrap-around is possible.
- DONE: outputs held; all detect edges ignored.
  - ack=1 clears timestamps, valid, done, timeout and elapsed; next state IDLE.
- ack in CAPTURE: abort. Clear as above and return to IDLE; done is not asserted.
- ack in IDLE: no effect.
- A detect held high through the ack clock does not retrigger; a new rising edge is required.
- Latency: valid/timestamp visible one register stage after the sampling edge. done asserts on the same edge as the final capture or the timeout decision.
- Minimum turnaround: ack clock -> IDLE -> an edge on the next clock is captured.

Test Plan (CHANNELS=4, CNT_WIDTH=16, TIMEOUT=20):
- Reset: rst=0 mid-CAPTURE with valid=4'b0011 -> all outputs 0 immediately (no clock); after release, idle with busy=0.
- Staggered: ch0 rises at k0, ch2 at k0+3, ch1 at k0+5, ch3 at k0+7.
  - Required: ts={ch0:0, ch1:5, ch2:3, ch3:7}; valid=4'b1111.
  - Required: done=1 and timeout=0 after edge k0+7; busy=1 from k0 to k0+6.
- Timeout: ch1 at k0, ch3 at k0+4, nothing else.
  - Required: at k0+20 done=1, timeout=1, valid=4'b1010, ts1=0, ts3=4, ts0=ts2=0.
- Boundary: ch0..ch2 at k0, ch3 at k0+20 -> ts3=20, done=1, timeout=0.
- Simultaneous/repeat: ch0 and ch1 at k0; ch0 pulses again at k0+2; ch2 and ch3 at k0+6.
  - Required: ts={0,0,6,6}, done=1 at k0+6, ch0 unchanged.
- Ack handling:
  - ack in DONE with ch0 detect still high -> cleared, IDLE, no retrigger until ch0 falls and rises again.
  - ack at k0+3 in CAPTURE -> abort, done never asserts, valid=0.
  - ack in IDLE -> no change.
